start_button_conditioner: RTL
=============================

// Module: start_button_conditioner
// PURPOSE
//  Conditions the raw board push-button into the single-cycle start strobe that the blinking
//  sequence FSM consumes on its start input. Stages: 2-FF synchronizer, polarity normalisation,
//  counter-based debounce FSM, rising-edge one-shot. Optional hold-off suppresses re-triggers
//  while a 31-cycle blink sequence runs. Sits between the top-level key pin and the FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES   16  consecutive equal synchronized samples needed to accept a level change (>=2)
//  HOLDOFF_CYCLES    31  cycles start_pulse is suppressed after a pulse (START_HOLDOFF_EN only; >=1)
//  BUTTON_ACTIVE_LOW 1   1: button_in low = pressed; 0: high = pressed
// PORTS
//  clk           input   1  system clock, all flops on posedge
//  reset         input   1  asynchronous, active-low reset
//  button_in     input   1  raw, asynchronous, bouncing key input
//  start_pulse   output  1  one-cycle strobe on each accepted press; drives the FSM start input
//  button_level  output  1  debounced pressed level (1 = pressed)
//  busy          output  1  hold-off window active; constant 0 without START_HOLDOFF_EN
// BEHAVIOUR
//  - Reset (reset==0, async): sync flops <= released level; state <= REL; cnt <= 0;
//    start_pulse, button_level, busy <= 0. All outputs are registered.
//  - Sync: s1 <= button_in, s2 <= s1; p = s2 ^ BUTTON_ACTIVE_LOW (1 = pressed).
//  - Debounce FSM, cnt width $clog2(DEBOUNCE_CYCLES)+1:
//    REL:       p -> PRESS_CHK, cnt<=1; else stay.
//    PRESS_CHK: !p -> REL, cnt<=0; cnt==DEBOUNCE_CYCLES-1 -> PRS, cnt<=0, button_level<=1,
//               accept edge; else cnt++.
//    PRS:       !p -> REL_CHK, cnt<=1; else stay.
//    REL_CHK:   p -> PRS, cnt<=0; cnt==DEBOUNCE_CYCLES-1 -> REL, cnt<=0, button_level<=0; else cnt++.
//    Unused encodings -> REL.
//  - start_pulse <= 1 for exactly one cycle on the clock edge where PRESS_CHK->PRS (accept edge),
//    else 0. Release never pulses. Holding the key produces one pulse only.
//  - Latency: button_in stable-pressed before edge 0 -> start_pulse and button_level high after
//    edge DEBOUNCE_CYCLES+1 (edge 17 for default). Release latency identical for button_level.
//  - Any bounce resets the candidate count to 0 via a return to the stable state; a glitch
//    shorter than DEBOUNCE_CYCLES samples never changes button_level.
//  - Reset mid-count: count discarded; after release of reset a still-pressed key needs a full
//    DEBOUNCE_CYCLES window and then pulses (reset returns to REL, not PRS).
//  - No counter wrap: cnt never exceeds DEBOUNCE_CYCLES-1.
// CONFIGURATION
//  START_HOLDOFF_EN defined: on each emitted pulse, hcnt <= HOLDOFF_CYCLES and busy <= 1;
//    hcnt decrements each cycle; busy <= 0 on the edge hcnt goes 1->0. An accept edge while
//    busy==1 gives no pulse and is dropped, not queued; button_level still tracks normally.
//    An accept edge on the same edge busy falls is also dropped (busy sampled pre-edge).
//  START_HOLDOFF_EN undefined: hold-off logic not instantiated, busy tied 0, every accept edge
//    pulses.
// TESTING (bench uses DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, BUTTON_ACTIVE_LOW=1)
//  1 Reset, hold button_in=1 for 10 cycles -> all outputs 0 throughout.
//  2 Drive button_in=0 before edge 0 and hold -> start_pulse=1 only in the cycle after edge 5,
//    button_level=1 from edge 5 onward; no second pulse within 50 held cycles.
//  3 Bounce pattern 0,0,1,0,0,0,1 (one sample/cycle) then 1 -> no pulse, button_level stays 0.
//  4 Press accepted, then button_in=1 for 3 cycles and back to 0 -> button_level stays 1, no new pulse;
//    then held 1 for 6 cycles -> button_level=0 after edge 5 of the release, no pulse.
//  5 Press, assert reset=0 for 1 cycle at count 2, keep pressed -> outputs 0 during reset; pulse
//    arrives DEBOUNCE_CYCLES+1 edges after the first edge with reset=1.
//  6 START_HOLDOFF_EN: press (pulse, busy=1), release + re-press accepted within 8 cycles -> no
//    second pulse, busy=0 after 8 edges; re-press after busy=0 -> pulse. Without macro: both pulse.

Source files
------------

// File: rtl/start_button_conditioner_if.sv
// start_button_conditioner_if: raw key in, conditioned strobe/level/busy out
interface start_button_conditioner_if;
  logic button_in;
  logic start_pulse;
  logic button_level;
  logic busy;
  modport master (output button_in, input start_pulse, button_level, busy);
  modport slave (input button_in, output start_pulse, button_level, busy);
endinterface

// File: rtl/start_button_conditioner.sv
// start_button_conditioner: sync, debounce and one-shot a raw key into a start strobe; START_HOLDOFF_EN adds a post-pulse hold-off
module start_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES = 31,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic reset,
  start_button_conditioner_if.slave btn
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {REL, PRESS_CHK, PRS, REL_CHK} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic s1, s2, p, accept, pulse, level, busy;
  if (DEBOUNCE_CYCLES < 2 || HOLDOFF_CYCLES < 1) begin : g_bad_params
    $error("start_button_conditioner: DEBOUNCE_CYCLES must be >= 2 and HOLDOFF_CYCLES >= 1");
  end
  assign p = s2 ^ BUTTON_ACTIVE_LOW;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= BUTTON_ACTIVE_LOW;
      s2 <= BUTTON_ACTIVE_LOW;
      state <= REL;
      cnt <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1 <= btn.button_in;
      s2 <= s1;
      state <= state_nx;
      cnt <= cnt_nx;
      level <= state_nx == PRS || state_nx == REL_CHK;
      pulse <= accept & ~busy;
    end
  always_comb begin
    state_nx = REL;
    cnt_nx = '0;
    accept = 1'b0;
    case (state)
      REL: begin
        state_nx = p ? PRESS_CHK : REL;
        cnt_nx = p ? ONE : '0;
      end
      PRESS_CHK: begin
        accept = p && cnt == LAST;
        state_nx = !p ? REL : accept ? PRS : PRESS_CHK;
        cnt_nx = (!p || accept) ? '0 : cnt + ONE;
      end
      PRS: begin
        state_nx = p ? PRS : REL_CHK;
        cnt_nx = p ? '0 : ONE;
      end
      REL_CHK: begin
        state_nx = p ? PRS : cnt == LAST ? REL : REL_CHK;
        cnt_nx = (p || cnt == LAST) ? '0 : cnt + ONE;
      end
      default: begin
        state_nx = REL;
        cnt_nx = '0;
      end
    endcase
  end
`ifdef START_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] hcnt;
  // an accept edge landing while busy (including the edge busy falls) is dropped, not queued
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hcnt <= '0;
      busy <= 1'b0;
    end else if (accept && !busy) begin
      hcnt <= HW'(HOLDOFF_CYCLES);
      busy <= 1'b1;
    end else if (busy) begin
      hcnt <= hcnt - HW'(1);
      busy <= hcnt != HW'(1);
    end
`else
  assign busy = 1'b0;
`endif
  assign btn.start_pulse = pulse;
  assign btn.button_level = level;
  assign btn.busy = busy;
endmodule
